// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1001 sequence detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StResult
  } state_e;

  localparam logic [3:0] Pattern = 4'b1001;

endpackage

// File: rtl/seq_det_core.sv
// Serial 1001 detector; flags overlapping matches once four bits have been fed since clr.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match
);

  logic [2:0] hist_q;
  logic [1:0] fed_q;

  // fed_q saturates at 3: the current bit makes the fourth
  assign match = bit_valid && (fed_q == 2'd3) && ({hist_q, bit_in} == Pattern);

  always_ff @(posedge clk) begin
    if (rstn || clr) begin
      hist_q <= '0;
      fed_q  <= '0;
    end else if (bit_valid) begin
      hist_q <= {hist_q[1:0], bit_in};
      if (fed_q != 2'd3) fed_q <= fed_q + 2'd1;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Two-requester round-robin front end that counts 1001 matches per accepted word.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned TOT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            req_valid,
  input  logic [2*WORD_W-1:0]   req_data,
  output logic [1:0]            req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_id,
  output logic [3:0]            res_count,
  output logic [TOT_W-1:0]      total_count,
  output logic                  busy
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);

  state_e            state_q;
  logic              last_q;
  logic              id_q;
  logic [WORD_W-1:0] word_q;
  logic [IdxW-1:0]   idx_q;
  logic [3:0]        cnt_q;
  logic              res_valid_q;
  logic [TOT_W-1:0]  total_q;

  logic              grant;
  logic              accept;
  logic              match;
  logic [TOT_W:0]    sum;

  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_q;
    else if (req_valid[1])  grant = 1'b1;
  end

  assign req_ready = (state_q == StIdle && !rstn && |req_valid) ? (2'b01 << grant) : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sum       = {1'b0, total_q} + {{(TOT_W - 3){1'b0}}, cnt_q};

  seq_det_core u_core (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (accept),
    .bit_valid (state_q == StShift),
    .bit_in    (word_q[WORD_W-1]),
    .match     (match)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      word_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      total_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            word_q  <= grant ? req_data[WORD_W +: WORD_W] : req_data[0 +: WORD_W];
            id_q    <= grant;
            last_q  <= grant;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          word_q <= word_q << 1;
          idx_q  <= idx_q + 1'b1;
          if (match) cnt_q <= cnt_q + 4'd1;
          if (idx_q == LastIdx) begin
            state_q     <= StResult;
            res_valid_q <= 1'b1;
          end
        end
        StResult: begin
          if (res_ready) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            total_q     <= sum[TOT_W] ? '1 : sum[TOT_W-1:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res_valid   = res_valid_q;
  assign res_id      = id_q;
  assign res_count   = cnt_q;
  assign total_count = total_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized bench for seq_det_sched against a word-level reference model.
module tb_seq_det_sched;

  localparam int W    = 8;
  localparam int TW   = 6;
  localparam int TMAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0]      req_valid;
  logic [2*W-1:0]  req_data;
  logic [1:0]      req_ready;
  logic            res_valid;
  logic            res_ready;
  logic            res_id;
  logic [3:0]      res_count;
  logic [TW-1:0]   total_count;
  logic            busy;

  int   checks = 0;
  int   errors = 0;
  logic last_m;
  int   total_m;

  seq_det_sched #(.WORD_W(W), .TOT_W(TW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_count   (res_count),
    .total_count (total_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count every MSB-first 4-bit window equal to 1001
  function automatic int ref_count(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i + 4 <= W; i++) if (w[W-1-i -: 4] == 4'b1001) n++;
    return n;
  endfunction

  task automatic do_word(input logic [1:0] v, input logic [2*W-1:0] d, input int stall,
                         input string tag, output logic obs_id);
    logic       g;
    logic [1:0] er;
    int         ec;
    req_valid = v;
    req_data  = d;
    res_ready = 1'b0;
    #1;
    g  = (v == 2'b11) ? ~last_m : v[1];
    er = g ? 2'b10 : 2'b01;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, er);
    end
    ec = ref_count(g ? d[W +: W] : d[0 +: W]);
    tick();
    last_m = g;
    for (int k = 1; k <= W; k++) begin
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL %s shift cycle %0d: res_valid=%b busy=%b req_ready=%b expected 0 1 00",
                 tag, k, res_valid, busy, req_ready);
      end
      req_valid = 2'($urandom);
      req_data  = (2*W)'($urandom);
      tick();
    end
    obs_id = res_id;
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (res_valid !== 1'b1 || res_id !== g || res_count !== 4'(ec) || busy !== 1'b1 ||
          req_ready !== 2'b00) begin
        errors++;
        $display("FAIL %s result hold %0d: valid=%b id=%b count=%0d busy=%b ready=%b expected 1 %b %0d 1 00",
                 tag, s, res_valid, res_id, res_count, busy, req_ready, g, ec);
      end
      if (s < stall) tick();
    end
    req_valid = 2'b11;
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL %s handshake ready: req_ready=%b expected 00", tag, req_ready);
    end
    tick();
    res_ready = 1'b0;
    req_valid = 2'b00;
    total_m = (total_m + ec > TMAX) ? TMAX : total_m + ec;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || total_count !== TW'(total_m)) begin
      errors++;
      $display("FAIL %s after handshake: busy=%b res_valid=%b total=%0d expected 0 0 %0d",
               tag, busy, res_valid, total_count, total_m);
    end
  endtask

  task automatic test_reset();
    rstn      = 1'b1;
    req_valid = 2'b11;
    req_data  = '0;
    res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 2'b00 || res_valid !== 1'b0 || res_id !== 1'b0 || res_count !== 4'd0 ||
        total_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset state: ready=%b valid=%b id=%b count=%0d total=%0d busy=%b expected all 0",
               req_ready, res_valid, res_id, res_count, total_count, busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset first contention: req_ready=%b expected 01", req_ready);
    end
    req_valid = 2'b00;
    last_m  = 1'b1;
    total_m = 0;
  endtask

  task automatic test_directed();
    logic id;
    do_word(2'b01, {8'hFF, 8'b1001_1001}, 0, "dir_1001_1001", id);
    do_word(2'b01, {8'h00, 8'b1001_0010}, 0, "dir_overlap", id);
    do_word(2'b01, {8'hFF, 8'b0000_0000}, 0, "dir_zero", id);
    do_word(2'b10, {8'b1001_1001, 8'h00}, 1, "dir_req1", id);
    checks++;
    if (id !== 1'b1) begin
      errors++;
      $display("FAIL dir_req1 id: res_id=%b expected 1", id);
    end
  endtask

  task automatic test_round_robin();
    logic id;
    logic [1:0] exp_seq;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      do_word(2'b11, (2*W)'($urandom), 0, "round_robin", id);
      exp_seq = 2'(i);
      checks++;
      if (id !== exp_seq[0]) begin
        errors++;
        $display("FAIL round_robin order %0d: res_id=%b expected %b", i, id, exp_seq[0]);
      end
    end
  endtask

  task automatic test_stall();
    logic id;
    do_word(2'b11, {8'b0100_1000, 8'b1001_1001}, 5, "stall", id);
  endtask

  task automatic test_saturation();
    logic id;
    test_reset();
    for (int i = 0; i < (TMAX - 1) / 2; i++)
      do_word(2'b01, {8'h00, 8'b1001_1001}, 0, "sat_fill", id);
    for (int i = 0; i < 2; i++) begin
      do_word(2'b01, {8'h00, 8'b1001_1001}, 0, "sat_top", id);
      checks++;
      if (total_count !== TW'(TMAX)) begin
        errors++;
        $display("FAIL saturation %0d: total=%0d expected %0d", i, total_count, TMAX);
      end
    end
  endtask

  task automatic test_random();
    logic id;
    logic [1:0] v;
    test_reset();
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      do_word(v, (2*W)'($urandom), $urandom_range(0, 3), "random", id);
    end
  endtask

  task automatic test_reset_mid();
    logic id;
    do_word(2'b01, {8'h00, 8'b1001_1001}, 0, "mid_pre", id);
    req_valid = 2'b11;
    req_data  = {8'b1001_1001, 8'b1001_1001};
    tick();
    for (int k = 1; k < 4; k++) tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    req_valid = 2'b00;
    last_m  = 1'b1;
    total_m = 0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || total_count !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b res_valid=%b total=%0d expected 0 0 0",
               busy, res_valid, total_count);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid idle %0d: res_valid=%b busy=%b expected 0 0", k, res_valid, busy);
      end
      tick();
    end
    do_word(2'b11, (2*W)'($urandom), 0, "mid_post", id);
    checks++;
    if (id !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid contention: res_id=%b expected 0", id);
    end
  endtask

  initial begin
    rstn      = 1'b1;
    req_valid = 2'b00;
    req_data  = '0;
    res_ready = 1'b0;
    test_reset();
    test_directed();
    test_round_robin();
    test_stall();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter WORD_W, default 8: bits per request word, shifted MSB-first.
REQ-002 Parameter TOT_W, default 16: width of the saturating total match counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-high: rstn=1 at a rising edge of clk resets the block.
REQ-005 req_valid  input  2  per-requester word-valid; bit n belongs to requester n.
REQ-006 req_data  input  2*WORD_W  requester n word on bits [n*WORD_W +: WORD_W].
REQ-007 req_ready  output  2  per-requester accept; a word transfers when req_valid[n] & req_ready[n].
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_id  output  1  requester index the result belongs to.
REQ-011 res_count  output  4  number of 1001 matches found in the word.
REQ-012 total_count  output  TOT_W  saturating sum of all delivered res_count values.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, RESULT.
REQ-015 In IDLE, req_ready SHALL be one-hot on the granted requester, or 0 when no req_valid bit is set; it is never asserted outside IDLE.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it regardless of history.
REQ-017 The last-grant pointer SHALL update only on an accepted transfer.
REQ-018 On accept, the block SHALL latch the word and the requester id, clear the detector and bit counter, and enter SHIFT.
REQ-019 SHIFT SHALL last exactly WORD_W cycles, feeding one bit per cycle MSB-first into the detector.
REQ-020 The detector SHALL flag a match on any cycle where the last 4 bits fed equal 1001 and at least 4 bits have been fed since the clear; matches may overlap.
REQ-021 Matches never span two words.
REQ-022 res_count SHALL increment on each flagged match.
REQ-023 res_valid SHALL assert on the cycle after the last SHIFT cycle; latency from the accept edge to res_valid is WORD_W+1 cycles.
REQ-024 In RESULT, res_valid, res_id and res_count SHALL hold stable until res_ready=1, then the block returns to IDLE on the next edge.
REQ-025 No new word SHALL be accepted in the same cycle as the result handshake.
REQ-026 On the result handshake, total_count SHALL add res_count and saturate at all-ones, never wrapping.
REQ-027 req_data and req_valid changes during SHIFT or RESULT SHALL have no effect.

Reset
REQ-028 On rstn=1: state=IDLE, req_ready=0, res_valid=0, res_id=0, res_count=0, total_count=0, busy=0, last-grant pointer=1 (requester 0 wins the first contention), detector cleared.
REQ-029 Reset asserted during SHIFT or RESULT SHALL abandon the word with no result delivered and no total_count update.

Structure
REQ-030 State encodings (IDLE/SHIFT/RESULT) and the pattern constant 4'b1001 SHALL live in a shared package seq_det_pkg.
REQ-031 The bit detector SHALL be a sub-module seq_det_core with inputs clk, rstn, clr, bit_valid, bit_in and output match, instantiated once.

Verification
REQ-032 Only req_valid=01, req_data[7:0]=8'b1001_1001 accepted at cycle 0 -> res_valid at cycle 9, res_id=0, res_count=2.
REQ-033 req_data[7:0]=8'b1001_0010 (overlap) -> res_count=2; 8'b0000_0000 -> res_count=0.
REQ-034 req_valid=11 held continuously, res_ready=1 -> grants alternate 0,1,0,1; first grant goes to 0.
REQ-035 res_ready=0 for 5 cycles in RESULT -> outputs stable, req_ready=00, busy=1; then res_ready=1 -> IDLE next cycle.
REQ-036 total_count preloaded near 16'hFFFE, then a word with res_count=2 delivered -> total_count=16'hFFFF.
REQ-037 rstn=1 at SHIFT cycle 4 -> next cycle IDLE, res_valid stays 0, total_count=0, requester 0 wins the next contention.
